// File: rtl/or_gate_arbiter.sv
// Round-robin arbiter sharing one registered OR datapath (y = a | b) between
// N_REQ valid/ready requesters, with a single-entry valid/ready result stage.
module or_gate_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int OP_W  = 8,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*OP_W-1:0] req_a,
  input  logic [N_REQ*OP_W-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [OP_W-1:0]       rsp_y,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy
);

  logic [ID_W-1:0] ptr_p0;
  logic [ID_W-1:0] win_p0;
  logic [ID_W-1:0] ptr_nxt_p0;
  logic            found_p0;
  logic [OP_W-1:0] or_p0;
  logic            can_accept_p0;

  logic            vld_p1;
  logic [OP_W-1:0] y_p1;
  logic [ID_W-1:0] id_p1;

  assign can_accept_p0 = !vld_p1 || rsp_ready;

  // Stage p0: pick the valid requester closest to ptr in round-robin order.
  always_comb begin
    int best_d;
    int d;
    found_p0  = 1'b0;
    win_p0    = '0;
    or_p0     = '0;
    req_ready = '0;
    best_d    = N_REQ;
    d         = 0;
    if (!rst && can_accept_p0) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i]) begin
          d = (i - int'(ptr_p0) + N_REQ) % N_REQ;
          if (d < best_d) begin
            best_d   = d;
            found_p0 = 1'b1;
            win_p0   = i[ID_W-1:0];
            or_p0    = req_a[i*OP_W +: OP_W] | req_b[i*OP_W +: OP_W];
          end
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = found_p0 && (win_p0 == i[ID_W-1:0]);
      end
    end
  end

  assign ptr_nxt_p0 = (win_p0 == ID_W'(N_REQ - 1)) ? '0 : win_p0 + 1'b1;

  // Stage p1: output register; a grant reloads it even while it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
      id_p1  <= '0;
      ptr_p0 <= '0;
    end else if (found_p0) begin
      vld_p1 <= 1'b1;
      y_p1   <= or_p0;
      id_p1  <= win_p0;
      ptr_p0 <= ptr_nxt_p0;
    end else if (rsp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_y     = y_p1;
  assign rsp_id    = id_p1;
  assign busy      = vld_p1;

endmodule
